sram_port_ctrl: RTL and testbench

- Initiator-side controller for the single-port RW OpenRAM macro (csb0/web0/addr0/din0/dout0, active-low selects).
- Converts a valid/ready request stream into correctly timed macro port cycles.
- Captures dout0 at the macro's fixed read latency and returns read data on a buffered valid/ready response stream.
- Optionally clears the whole array after reset. Sits between a core-side requester and the macro instance.

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_rsp_fifo.sv | 64 ++++++
 rtl/sram_port_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_port_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM type and constants for the OpenRAM
// single-port controller (sram_port_ctrl and sram_rsp_fifo).
package sram_ctrl_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    // Cycles from request accept until dout0 is captured.
    localparam int READ_LAT   = 2;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: in-order response buffer with full/empty flags.
// The head entry is presented combinationally from storage.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Credit gating upstream should make this unreachable.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && full)
    );

endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: request/response front end for a single-port OpenRAM macro.
// Define SRAM_CTRL_WR_ACK_EN to return a tagged ack (rsp_is_wr) for writes.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RSP_DEPTH      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef SRAM_CTRL_WR_ACK_EN
    output logic              rsp_is_wr,
`endif
    output logic              init_done,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0
);

    localparam int CR_W = $clog2(RSP_DEPTH + 1);
`ifdef SRAM_CTRL_WR_ACK_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [CR_W-1:0]   credit;
    logic [CR_W-1:0]   credit_nx;
    logic [READ_LAT-1:0] pipe_v;
    logic              accept;
    logic              take;
    logic              pop;
    logic [FIFO_W-1:0] push_data;
    logic [FIFO_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;

    assign accept = req_valid && req_ready;
    assign pop    = rsp_valid && rsp_ready;

`ifdef SRAM_CTRL_WR_ACK_EN
    assign take = accept;
`else
    assign take = accept && !req_we;
`endif

    // Credit covers everything that will eventually need a buffer slot.
    always_comb begin
        credit_nx = credit;
        if (take && !pop) begin
            credit_nx = credit + 1'b1;
        end else if (!take && pop) begin
            credit_nx = credit - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_addr  <= '0;
            csb0      <= 1'b1;
            web0      <= 1'b1;
            addr0     <= '0;
            din0      <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            credit    <= '0;
            pipe_v    <= '0;
        end else begin
            credit <= credit_nx;
            pipe_v <= {pipe_v[READ_LAT-2:0], take};
            unique case (state)
                CLEAR: begin
                    csb0     <= 1'b0;
                    web0     <= 1'b0;
                    din0     <= '0;
                    addr0    <= clr_addr;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                        req_ready <= (credit_nx < CR_W'(RSP_DEPTH));
                    end
                end
                RUN: begin
                    init_done <= 1'b1;
                    req_ready <= (credit_nx < CR_W'(RSP_DEPTH));
                    csb0      <= !accept;
                    web0      <= !(accept && req_we);
                    if (accept) begin
                        addr0 <= req_addr;
                        din0  <= req_wdata;
                    end
                end
            endcase
        end
    end

`ifdef SRAM_CTRL_WR_ACK_EN
    logic [READ_LAT-1:0] pipe_wr;
    logic [DATA_W-1:0]   pipe_wd [READ_LAT];

    // Write acks ride alongside the read pipeline so ordering is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_wr <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_wd[i] <= '0;
            end
        end else begin
            pipe_wr    <= {pipe_wr[READ_LAT-2:0], accept && req_we};
            pipe_wd[0] <= req_wdata;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_wd[i] <= pipe_wd[i-1];
            end
        end
    end

    assign push_data = pipe_wr[READ_LAT-1]
                     ? {1'b1, pipe_wd[READ_LAT-1]}
                     : {1'b0, dout0};
    assign rsp_is_wr = head[DATA_W];
`else
    assign push_data = dout0;
`endif

    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = head[DATA_W-1:0];

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (FIFO_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pipe_v[READ_LAT-1]),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed scoreboard bench for sram_port_ctrl driving a
// behavioural single-port macro model. Follows SRAM_CTRL_WR_ACK_EN if set.
`timescale 1ns/1ps
module tb_sram_port_ctrl;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
`ifdef SRAM_CTRL_WR_ACK_EN
    logic              rsp_is_wr;
`endif
    logic              init_done;
    logic              csb0;
    logic              web0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] dout0;

    always #5 clk = ~clk;

    sram_port_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .RSP_DEPTH      (4),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
`ifdef SRAM_CTRL_WR_ACK_EN
        .rsp_is_wr (rsp_is_wr),
`endif
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    // Macro model: samples the port on the edge, dout0 valid the next cycle.
    logic [DATA_W-1:0] mem [DEPTH];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hEE;
            mem_init <= 1'b1;
        end else if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0 <= mem[addr0];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    int rsp_cnt = 0;
    int last_rsp_cyc = 0;
    int stalls = 0;
    int acc_cyc = 0;
    logic [DATA_W:0] exp_q [$];

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        logic [DATA_W:0] g;
        #1;
        if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
`ifdef SRAM_CTRL_WR_ACK_EN
            g = {rsp_is_wr, rsp_rdata};
`else
            g = {1'b0, rsp_rdata};
`endif
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got %h, required no response", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got %h, required %h", g, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_csb0"}, 32'(csb0), 1);
        chk({tag, "_web0"}, 32'(web0), 1);
        chk({tag, "_addr0"}, 32'(addr0), 0);
        chk({tag, "_din0"}, 32'(din0), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        chk({tag, "_init_done"}, 32'(init_done), 0);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: got req_ready=0, required 1");
            req_valid = 1'b0;
            return;
        end
        stalls += n;
        if (!we) exp_q.push_back({1'b0, e});
`ifdef SRAM_CTRL_WR_ACK_EN
        else exp_q.push_back({1'b1, d});
`endif
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_drain_left"}, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_clr_csb0"}, 32'(csb0), 0);
                chk({tag, "_clr_addr0"}, 32'(addr0), 0);
            end
            if (n == 300) chk({tag, "_clr_req_ready"}, 32'(req_ready), 0);
        end
        chk({tag, "_clear_cycles"}, 32'(n), 512);
    endtask

    initial begin
        int base;
        int acc;
        int t;
        logic rdy;
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc;
        int first;
        logic rdy;

        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        wait_init("init");

        issue(1'b0, 9'd0, 8'h00, 8'h00);
        issue(1'b0, 9'd255, 8'h00, 8'h00);
        issue(1'b0, 9'd511, 8'h00, 8'h00);
        req_valid = 1'b0;
        drain("clear_rd");

        issue(1'b1, 9'h1F3, 8'hA5, 8'h00);
        chk("wr_csb0", 32'(csb0), 0);
        chk("wr_web0", 32'(web0), 0);
        chk("wr_addr0", 32'(addr0), 32'h1F3);
        chk("wr_din0", 32'(din0), 32'hA5);
        issue(1'b0, 9'h1F3, 8'h00, 8'hA5);
        chk("rd_csb0", 32'(csb0), 0);
        chk("rd_web0", 32'(web0), 1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_csb0", 32'(csb0), 1);
`ifndef SRAM_CTRL_WR_ACK_EN
        chk("raw_e1_valid", 32'(rsp_valid), 0);
`endif
        @(negedge clk);
        chk("raw_e2_valid", 32'(rsp_valid), 1);
        chk("raw_e2_rdata", 32'(rsp_rdata), 32'hA5);
        drain("raw");

        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 9'h040 + 9'(i), 8'h60 + 8'(i), 8'h00);
        end
        req_valid = 1'b0;
        drain("wr16");
        stalls = 0;
        base = rsp_cnt;
        first = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 9'h040 + 9'(i), 8'h00, 8'h60 + 8'(i));
            if (i == 0) first = acc_cyc;
        end
        req_valid = 1'b0;
        drain("stream");
        chk("stream_stalls", 32'(stalls), 0);
        chk("stream_count", 32'(rsp_cnt - base), 16);
        chk("stream_last_cyc", 32'(last_rsp_cyc), 32'(first + 17));

        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 9'h040;
        for (int k = 0; k < 10; k++) begin
            rdy = req_ready;
            if (rdy) exp_q.push_back({1'b0, 8'h60 + 8'(acc)});
            @(negedge clk);
            if (rdy) begin
                acc++;
                req_addr = 9'h040 + 9'(acc);
            end
        end
        req_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 4);
        chk("bp_req_ready", 32'(req_ready), 0);
        chk("bp_head_valid", 32'(rsp_valid), 1);
        chk("bp_head_rdata", 32'(rsp_rdata), 32'h60);
        repeat (3) @(negedge clk);
        chk("bp_hold_valid", 32'(rsp_valid), 1);
        chk("bp_hold_rdata", 32'(rsp_rdata), 32'h60);
        base = rsp_cnt;
        rsp_ready = 1'b1;
        drain("bp");
        chk("bp_count", 32'(rsp_cnt - base), 4);
        chk("bp_ready_back", 32'(req_ready), 1);

`ifdef SRAM_CTRL_WR_ACK_EN
        issue(1'b1, 9'h005, 8'h3C, 8'h00);
        req_valid = 1'b0;
        @(negedge clk);
        chk("ack_e1_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("ack_e2_valid", 32'(rsp_valid), 1);
        chk("ack_is_wr", 32'(rsp_is_wr), 1);
        chk("ack_rdata", 32'(rsp_rdata), 32'h3C);
        drain("ack");
`endif

        issue(1'b0, 9'h040, 8'h00, 8'h60);
        issue(1'b0, 9'h041, 8'h00, 8'h61);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        exp_q.delete();
        base = rsp_cnt;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit");
        repeat (10) @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_cnt - base), 0);
        issue(1'b0, 9'h1F3, 8'h00, 8'h00);
        req_valid = 1'b0;
        drain("reclear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
